// File: rtl/apb_master_ctrl.sv
// APB initiator: queued commands run as SETUP/ACCESS transfers; push-to-response 3 cycles, one transfer per 2 cycles.
// Backpressure: req_ready drops when the command FIFO is full; rsp_* is a one-cycle strobe with no backpressure.
module apb_master_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 2
) (
    input  logic              Pclk,
    input  logic              Preset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [3:0]        Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Pwrite,
    output logic              Penable,
    input  logic [DATA_W-1:0] Prdata
);

    localparam int CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    cmd_t             fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop, empty;
    cmd_t             head;
    logic [3:0]       head_sel;
    logic             head_err;

    state_t              state, state_nx;
    logic [3:0]          psel_nx;
    logic                penable_nx, pwrite_nx;
    logic [ADDR_W-1:0]   paddr_nx;
    logic [DATA_W-1:0]   pwdata_nx, rsp_rdata_nx;
    logic                rsp_valid_nx, rsp_write_nx, rsp_err_nx;
    // An error popped during ACCESS is reported one cycle later to avoid two strobes colliding.
    logic                err_pend, err_pend_nx, err_write, err_write_nx;

    assign req_ready = (count < CNT_W'(CMD_DEPTH));
    assign empty     = (count == '0);
    assign push      = req_valid && req_ready;
    assign head      = fifo_mem[rd_ptr];

    always_comb begin
        head_sel = 4'b0000;
        head_err = 1'b0;
        case (head.addr[31:26])
            6'h20:   head_sel = 4'b0001;
            6'h21:   head_sel = 4'b0010;
            6'h22:   head_sel = 4'b0100;
            6'h23:   head_sel = 4'b1000;
            default: head_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nx     = state;
        pop          = 1'b0;
        psel_nx      = Pselx;
        penable_nx   = Penable;
        pwrite_nx    = Pwrite;
        paddr_nx     = Paddr;
        pwdata_nx    = Pwdata;
        rsp_valid_nx = 1'b0;
        rsp_write_nx = rsp_write;
        rsp_err_nx   = rsp_err;
        rsp_rdata_nx = rsp_rdata;
        err_pend_nx  = err_pend;
        err_write_nx = err_write;
        case (state)
            IDLE: begin
                psel_nx    = 4'b0000;
                penable_nx = 1'b0;
                if (err_pend) begin
                    rsp_valid_nx = 1'b1;
                    rsp_write_nx = err_write;
                    rsp_err_nx   = 1'b1;
                    rsp_rdata_nx = '0;
                    err_pend_nx  = 1'b0;
                end else if (!empty) begin
                    pop = 1'b1;
                    if (head_err) begin
                        rsp_valid_nx = 1'b1;
                        rsp_write_nx = head.write;
                        rsp_err_nx   = 1'b1;
                        rsp_rdata_nx = '0;
                    end else begin
                        psel_nx   = head_sel;
                        pwrite_nx = head.write;
                        paddr_nx  = head.addr;
                        pwdata_nx = head.wdata;
                        state_nx  = SETUP;
                    end
                end
            end
            SETUP: begin
                penable_nx = 1'b1;
                state_nx   = ACCESS;
            end
            ACCESS: begin
                rsp_valid_nx = 1'b1;
                rsp_write_nx = Pwrite;
                rsp_err_nx   = 1'b0;
                rsp_rdata_nx = Pwrite ? '0 : Prdata;
                penable_nx   = 1'b0;
                if (!empty) begin
                    pop = 1'b1;
                    if (head_err) begin
                        psel_nx      = 4'b0000;
                        err_pend_nx  = 1'b1;
                        err_write_nx = head.write;
                        state_nx     = IDLE;
                    end else begin
                        psel_nx   = head_sel;
                        pwrite_nx = head.write;
                        paddr_nx  = head.addr;
                        pwdata_nx = head.wdata;
                        state_nx  = SETUP;
                    end
                end else begin
                    psel_nx  = 4'b0000;
                    state_nx = IDLE;
                end
            end
            default: begin
                psel_nx    = 4'b0000;
                penable_nx = 1'b0;
                state_nx   = IDLE;
            end
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
        end
    end

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            err_pend  <= 1'b0;
            err_write <= 1'b0;
        end else begin
            state     <= state_nx;
            Pselx     <= psel_nx;
            Penable   <= penable_nx;
            Pwrite    <= pwrite_nx;
            Paddr     <= paddr_nx;
            Pwdata    <= pwdata_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_write <= rsp_write_nx;
            rsp_err   <= rsp_err_nx;
            rsp_rdata <= rsp_rdata_nx;
            err_pend  <= err_pend_nx;
            err_write <= err_write_nx;
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(CMD_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(CMD_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

APB-side initiator of the AHB-to-APB bridge. Accepts single read/write commands from the bridge core on a valid/ready port, buffers them in a small command FIFO, and runs each as a two-phase APB transfer: SETUP, then ACCESS. It decodes the address to one of four `Pselx` slave selects and returns read data or a decode error on a one-cycle response strobe. It is the transfer-generating counterpart of the APB slave responder that drives `Prdata`.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `CMD_DEPTH`, 2: command FIFO entries (≥1).

Ports:
- `Pclk`  in  1  single clock, all logic on posedge.
- `Preset`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  FIFO not full.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle completion strobe, no backpressure.
- `rsp_write`  out  1  direction of the completed command.
- `rsp_err`  out  1  decode error.
- `rsp_rdata`  out  DATA_W  captured `Prdata`. 0 for writes and errors.
- `Pselx`  out  4  one-hot slave select.
- `Paddr`  out  ADDR_W  APB address.
- `Pwdata`  out  DATA_W  APB write data.
- `Pwrite`  out  1  APB direction.
- `Penable`  out  1  ACCESS phase indicator.
- `Prdata`  in  DATA_W  slave read data, sampled at the edge that ends ACCESS.

## Operation
- Push: a command is pushed on a posedge with `req_valid && req_ready`. `req_ready = (count < CMD_DEPTH)`, registered-count based. There is no pop-through when full.
- Decode is applied at pop, on `addr[31:26]`:
  - 0x20 (0x8000_0000–0x83FF_FFFF) → `Pselx = 4'b0001`
  - 0x21 (0x8400_0000–0x87FF_FFFF) → `4'b0010`
  - 0x22 (0x8800_0000–0x8BFF_FFFF) → `4'b0100`
  - 0x23 (0x8C00_0000–0x8FFF_FFFF) → `4'b1000`
  - any other value → decode error.
- FSM states are IDLE, SETUP and ACCESS. All APB outputs are registered.
  - **IDLE:** if the FIFO is non-empty, pop.
    - Valid decode → SETUP: load `Paddr`, `Pwrite`, `Pwdata` and `Pselx`; `Penable` = 0.
    - Decode error → stay in IDLE; `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0; no APB activity.
  - **SETUP:** → ACCESS unconditionally; `Penable` = 1. All other APB outputs hold.
  - **ACCESS:** capture `Prdata` on reads and assert `rsp_valid` (`rsp_err` = 0).
    - FIFO non-empty with a valid decode → pop and go directly to SETUP. `Pselx` is reloaded (it stays nonzero if the same slave is selected) and `Penable` = 0.
    - FIFO non-empty with a decode-error command → pop it and go to IDLE with `Pselx` = 0. Its error response is deferred one cycle, so it does not collide with the current response.
    - Otherwise → IDLE with `Pselx` = 0 and `Penable` = 0.
- At most one pop per posedge. Push and pop in the same edge are legal: count is unchanged.
- In IDLE, `Paddr`, `Pwdata` and `Pwrite` hold their last values. Only `Pselx` and `Penable` return to 0.
- `rsp_*` fields are valid only while `rsp_valid` is high; otherwise they hold their previous values.
- FIFO pointers wrap modulo `CMD_DEPTH`. Count width is `$clog2(CMD_DEPTH+1)`.

## Timing
- Reset values (on a posedge with `Preset` = 1):
  - all outputs 0 except `req_ready` = 1;
  - FIFO empty; state IDLE.
- Reset mid-transfer: the next edge forces `Pselx` = 0, `Penable` = 0 and state IDLE. Queued commands are discarded and no response is generated for the aborted transfer.
- Latency, with the push at edge E0:
  - E1: pop, SETUP outputs visible.
  - E2: ACCESS (`Penable` = 1).
  - E3: `Prdata` sampled; `rsp_valid` is high in the cycle after E3.
- An idle-start transfer therefore has 3 cycles of latency from push to response.
- Back-to-back throughput is one transfer per 2 cycles, and `Pselx` stays asserted continuously across same-slave transfers.
- A decode error from IDLE responds in the cycle after the pop edge.
- No wait states: the slave must return `Prdata` within the ACCESS cycle.

## Test plan
- Reset: hold `Preset` for 2 edges → `Pselx` = 0, `Penable` = 0, `rsp_valid` = 0, `req_ready` = 1.
- Write, `addr` = 0x8400_0010, `wdata` = 0xDEADBEEF → `Pselx` = 4'b0010 for exactly 2 cycles with `Penable` = 0 then 1, `Pwrite` = 1, `Pwdata` = 0xDEADBEEF; then `rsp_valid` pulses with `rsp_err` = 0 and `rsp_rdata` = 0.
- Read, `addr` = 0x8C00_0004, with the slave driving `Prdata` = 0x1234_5678 in ACCESS → `Pselx` = 4'b1000; `rsp_rdata` = 0x1234_5678, 3 cycles after the push.
- Three back-to-back writes to 0x8000_0000/04/08 → `Penable` sequence 0,1,0,1,0,1 with `Pselx` = 4'b0001 throughout; `req_ready` drops while 2 commands are queued; 3 responses in order.
- Read at 0x9000_0000 → no `Pselx` activity; `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0. The following valid command then proceeds normally.
- Assert `Preset` for one edge during ACCESS with one command queued → next cycle `Pselx` = 0, `Penable` = 0, no `rsp_valid`, `req_ready` = 1, and no later transfer occurs.
